// File: rtl/float_mon_pkg.sv
// Shared float field widths and class codes for the float classification monitor.
// Used by float_classify and float_class_monitor.
package float_mon_pkg;
    localparam int EXP_W = 8;
    localparam int MAN_W = 23;
    localparam logic [EXP_W-1:0] EXP_MAX = 8'd255;
    localparam int NUM_CLASSES = 6;

    typedef enum logic [2:0] {
        CLS_ZERO      = 3'd0,
        CLS_SUBNORMAL = 3'd1,
        CLS_NORMAL    = 3'd2,
        CLS_INF       = 3'd3,
        CLS_QNAN      = 3'd4,
        CLS_SNAN      = 3'd5
    } float_class_e;
endpackage

// File: rtl/float_classify.sv
// Purely combinational IEEE-754 single-precision classifier: class code and sign.
// Sign is ignored when choosing the class.
module float_classify
    import float_mon_pkg::*;
(
    input  logic [31:0] num_i,
    output logic [2:0]  class_o,
    output logic        sign_o
);
    logic [EXP_W-1:0] exp_w;
    logic [MAN_W-1:0] man_w;

    assign exp_w  = num_i[30:23];
    assign man_w  = num_i[22:0];
    assign sign_o = num_i[31];

    always_comb begin
        class_o = CLS_NORMAL;
        if (exp_w == '0) begin
            class_o = (man_w == '0) ? CLS_ZERO : CLS_SUBNORMAL;
        end else if (exp_w == EXP_MAX) begin
            if (man_w == '0)
                class_o = CLS_INF;
            else if (man_w[MAN_W-1])
                class_o = CLS_QNAN;
            else
                class_o = CLS_SNAN;
        end
    end
endmodule

// File: rtl/float_class_monitor.sv
// Two-stage float sample monitor: classifies samples, keeps saturating per-class counts.
// Optional FLOAT_MON_MAXMAG_EN tracks the largest finite magnitude seen on max_mag.
module float_class_monitor
    import float_mon_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [31:0]      in_num,
    input  logic             clear,
    input  logic [2:0]       sel_class,
    output logic             out_valid,
    output logic [2:0]       out_class,
    output logic             out_sign,
    output logic [CNT_W-1:0] cnt_out,
    output logic [30:0]      max_mag
);
    localparam logic [CNT_W-1:0] CNT_ONE = 1;

    logic             s1_valid_q;
    logic [31:0]      s1_num_q;
    logic             out_valid_q;
    logic [2:0]       out_class_q, out_class_d;
    logic             out_sign_q, out_sign_d;
    logic [CNT_W-1:0] cnt_q [NUM_CLASSES];
    logic [CNT_W-1:0] cnt_d [NUM_CLASSES];
    logic [CNT_W-1:0] cnt_out_q, cnt_out_d;
    logic [2:0]       cls_w;
    logic             sign_w;

    float_classify u_classify (
        .num_i   (s1_num_q),
        .class_o (cls_w),
        .sign_o  (sign_w)
    );

    // Class/sign hold their last value while no sample completes stage 2.
    always_comb begin
        out_class_d = out_class_q;
        out_sign_d  = out_sign_q;
        if (s1_valid_q) begin
            out_class_d = cls_w;
            out_sign_d  = sign_w;
        end
    end

    // A sample completing on a clear edge is output but not counted.
    always_comb begin
        cnt_out_d = '0;
        for (int i = 0; i < NUM_CLASSES; i++) begin
            cnt_d[i] = cnt_q[i];
            if (clear)
                cnt_d[i] = '0;
            else if (s1_valid_q && cls_w == 3'(i) && cnt_q[i] != '1)
                cnt_d[i] = cnt_q[i] + CNT_ONE;
            if (sel_class == 3'(i))
                cnt_out_d = cnt_d[i];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_q  <= 1'b0;
            s1_num_q    <= '0;
            out_valid_q <= 1'b0;
            out_class_q <= '0;
            out_sign_q  <= 1'b0;
            cnt_out_q   <= '0;
            for (int i = 0; i < NUM_CLASSES; i++)
                cnt_q[i] <= '0;
        end else begin
            s1_valid_q  <= in_valid;
            s1_num_q    <= in_num;
            out_valid_q <= s1_valid_q;
            out_class_q <= out_class_d;
            out_sign_q  <= out_sign_d;
            cnt_out_q   <= cnt_out_d;
            for (int i = 0; i < NUM_CLASSES; i++)
                cnt_q[i] <= cnt_d[i];
        end
    end

`ifdef FLOAT_MON_MAXMAG_EN
    logic [30:0] max_q, max_d;

    // Only finite classes (ZERO/SUBNORMAL/NORMAL) take part in the maximum.
    always_comb begin
        max_d = max_q;
        if (clear)
            max_d = '0;
        else if (s1_valid_q && cls_w <= CLS_NORMAL && s1_num_q[30:0] > max_q)
            max_d = s1_num_q[30:0];
    end

    always_ff @(posedge clk) begin
        if (rst)
            max_q <= '0;
        else
            max_q <= max_d;
    end

    assign max_mag = max_q;
`else
    assign max_mag = '0;
`endif

    assign out_valid = out_valid_q;
    assign out_class = out_class_q;
    assign out_sign  = out_sign_q;
    assign cnt_out   = cnt_out_q;
endmodule

// File: tb/tb_float_class_monitor.sv
// Directed bench for float_class_monitor: a 16-bit and a 4-bit counter instance share stimulus.
// Expected max_mag follows FLOAT_MON_MAXMAG_EN.
module tb_float_class_monitor;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic [31:0] in_num = '0;
    logic        clear = 1'b0;
    logic [2:0]  sel_class = '0;

    logic        ov_a, ov_b;
    logic [2:0]  cls_a, cls_b;
    logic        sgn_a, sgn_b;
    logic [15:0] cnt_a;
    logic [3:0]  cnt_b;
    logic [30:0] max_a, max_b;

    int n_cmp = 0;
    int n_err = 0;

`ifdef FLOAT_MON_MAXMAG_EN
    localparam bit MAXMAG_EN = 1'b1;
`else
    localparam bit MAXMAG_EN = 1'b0;
`endif

    float_class_monitor #(.CNT_W(16)) dut_a (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_num(in_num), .clear(clear),
        .sel_class(sel_class), .out_valid(ov_a), .out_class(cls_a), .out_sign(sgn_a),
        .cnt_out(cnt_a), .max_mag(max_a)
    );

    float_class_monitor #(.CNT_W(4)) dut_b (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_num(in_num), .clear(clear),
        .sel_class(sel_class), .out_valid(ov_b), .out_class(cls_b), .out_sign(sgn_b),
        .cnt_out(cnt_b), .max_mag(max_b)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic pulse_clear();
        clear = 1'b1;
        tick();
        clear = 1'b0;
    endtask

    initial begin
        // Reset state
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        check("rst_out_valid", 32'(ov_a), 32'd0);
        check("rst_out_class", 32'(cls_a), 32'd0);
        check("rst_out_sign", 32'(sgn_a), 32'd0);
        check("rst_cnt_out", 32'(cnt_a), 32'd0);
        check("rst_max_mag", 32'(max_a), 32'd0);

        // 1.0, smallest subnormal, -0.0 back to back
        in_valid = 1'b1;
        in_num = 32'h3F80_0000;
        tick();
        check("lat_not_early", 32'(ov_a), 32'd0);
        in_num = 32'h0000_0001;
        tick();
        check("s0_valid", 32'(ov_a), 32'd1);
        check("s0_class", 32'(cls_a), 32'd2);
        check("s0_sign", 32'(sgn_a), 32'd0);
        in_num = 32'h8000_0000;
        tick();
        check("s1_class", 32'(cls_a), 32'd1);
        check("s1_sign", 32'(sgn_a), 32'd0);
        in_valid = 1'b0;
        in_num = 32'h7F80_0000;
        tick();
        check("s2_valid", 32'(ov_a), 32'd1);
        check("s2_class", 32'(cls_a), 32'd0);
        check("s2_sign", 32'(sgn_a), 32'd1);
        tick();
        check("idle_valid", 32'(ov_a), 32'd0);
        check("hold_class", 32'(cls_a), 32'd0);
        check("hold_sign", 32'(sgn_a), 32'd1);
        sel_class = 3'd2;
        tick();
        check("cnt_normal_1", 32'(cnt_a), 32'd1);

        // Specials: +inf, qNaN, sNaN, -inf
        in_valid = 1'b1;
        in_num = 32'h7F80_0000;
        tick();
        in_num = 32'h7FC0_0000;
        tick();
        check("inf_class", 32'(cls_a), 32'd3);
        in_num = 32'h7F80_0001;
        tick();
        check("qnan_class", 32'(cls_a), 32'd4);
        in_num = 32'hFF80_0000;
        tick();
        check("snan_class", 32'(cls_a), 32'd5);
        in_valid = 1'b0;
        tick();
        check("ninf_class", 32'(cls_a), 32'd3);
        check("ninf_sign", 32'(sgn_a), 32'd1);
        tick();
        sel_class = 3'd3;
        tick();
        check("cnt_inf_a", 32'(cnt_a), 32'd2);
        check("cnt_inf_b", 32'(cnt_b), 32'd2);
        sel_class = 3'd4;
        tick();
        check("cnt_qnan", 32'(cnt_a), 32'd1);
        sel_class = 3'd5;
        tick();
        check("cnt_snan", 32'(cnt_a), 32'd1);
        sel_class = 3'd0;
        tick();
        check("cnt_zero", 32'(cnt_a), 32'd1);
        sel_class = 3'd6;
        tick();
        check("cnt_sel6", 32'(cnt_a), 32'd0);
        sel_class = 3'd7;
        tick();
        check("cnt_sel7", 32'(cnt_a), 32'd0);
        check("max_after_specials", 32'(max_a), MAXMAG_EN ? 32'h3F80_0000 : 32'd0);

        // Clear on the edge a sample reaches stage 2
        in_valid = 1'b1;
        in_num = 32'h4000_0000;
        tick();
        in_valid = 1'b0;
        clear = 1'b1;
        tick();
        clear = 1'b0;
        check("clr_valid", 32'(ov_a), 32'd1);
        check("clr_class", 32'(cls_a), 32'd2);
        check("clr_max", 32'(max_a), 32'd0);
        for (int s = 0; s < 6; s++) begin
            sel_class = 3'(s);
            tick();
            check($sformatf("clr_cnt_a%0d", s), 32'(cnt_a), 32'd0);
            check($sformatf("clr_cnt_b%0d", s), 32'(cnt_b), 32'd0);
        end
        in_valid = 1'b1;
        in_num = 32'h0000_0001;
        tick();
        in_valid = 1'b0;
        tick();
        sel_class = 3'd1;
        tick();
        check("post_clr_cnt", 32'(cnt_a), 32'd1);
        check("post_clr_max", 32'(max_a), MAXMAG_EN ? 32'h0000_0001 : 32'd0);

        // Saturation: 20 then 23 normals
        pulse_clear();
        in_valid = 1'b1;
        in_num = 32'h3F80_0000;
        for (int i = 0; i < 20; i++)
            tick();
        in_valid = 1'b0;
        tick();
        tick();
        sel_class = 3'd2;
        tick();
        check("sat_b_15", 32'(cnt_b), 32'd15);
        check("sat_a_20", 32'(cnt_a), 32'd20);
        in_valid = 1'b1;
        for (int i = 0; i < 3; i++)
            tick();
        in_valid = 1'b0;
        tick();
        tick();
        tick();
        check("sat_b_hold", 32'(cnt_b), 32'd15);
        check("sat_a_23", 32'(cnt_a), 32'd23);

        // Max magnitude: finite values compete, +inf is ignored
        pulse_clear();
        in_valid = 1'b1;
        in_num = 32'h7E4C_CCCC;
        tick();
        in_num = 32'hBDCC_CCCC;
        tick();
        in_num = 32'h7F80_0000;
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        check("max_a", 32'(max_a), MAXMAG_EN ? 32'h7E4C_CCCC : 32'd0);
        check("max_b", 32'(max_b), MAXMAG_EN ? 32'h7E4C_CCCC : 32'd0);

        // Reset with two samples in flight
        in_valid = 1'b1;
        in_num = 32'h3F80_0000;
        tick();
        in_num = 32'h0000_0000;
        rst = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check($sformatf("rst_flight_valid%0d", i), 32'(ov_a | ov_b), 32'd0);
        end
        for (int s = 0; s < 6; s++) begin
            sel_class = 3'(s);
            tick();
            check($sformatf("rst_cnt_a%0d", s), 32'(cnt_a), 32'd0);
            check($sformatf("rst_cnt_b%0d", s), 32'(cnt_b), 32'd0);
        end
        check("rst_flight_max", 32'(max_a), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
